// File: rtl/video_ts_spr_scan_pkg.sv
// Shared definitions for the TS sprite scanner: descriptor layout, FSM states, clip helper.
package video_ts_spr_scan_pkg;

    // Words per sprite descriptor in the sprite file
    localparam int unsigned SPR_WORDS = 3;

    // R0 field positions
    localparam int unsigned R0_Y_LSB   = 0;
    localparam int unsigned R0_YSZ_LSB = 9;
    localparam int unsigned R0_ACT     = 13;
    localparam int unsigned R0_LEAP    = 14;
    localparam int unsigned R0_YFLP    = 15;

    // R1 field positions
    localparam int unsigned R1_X_LSB   = 0;
    localparam int unsigned R1_XSZ_LSB = 9;
    localparam int unsigned R1_XFLP    = 15;

    // R2 field positions
    localparam int unsigned R2_TNUM_LSB = 0;
    localparam int unsigned R2_PAL_LSB  = 12;

    typedef enum logic [2:0] {
        StIdle,
        StRd0Pre,
        StRd0,
        StRd1Pre,
        StRd1,
        StRd2,
        StIssue,
        StDone
    } scan_state_e;

    // A sprite is kept unless it starts past the visible width and does not wrap back
    // through X=0 on the 512-pixel ring.
    function automatic logic x_visible(input logic [8:0] x, input logic [2:0] xsz,
                                       input logic [9:0] screen_w);
        logic [9:0] x_end;
        x_end = {1'b0, x} + {4'b0000, xsz, 3'b000} + 10'd8;
        return ({1'b0, x} < screen_w) || (x_end > 10'd512);
    endfunction

endpackage

// File: rtl/video_ts_spr_scan_dpram.sv
// Sprite file storage: one write port, one registered read port (old data on collision).
module video_ts_spr_scan_dpram #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
) (
    input  logic          i_clk,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_we,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rd_data;

    // Write and read share the edge, so a same-address read returns the previous word
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/video_ts_spr_scan.sv
// TS sprite scanner: walks the sprite file once per line and issues render tasks per layer.
module video_ts_spr_scan
    import video_ts_spr_scan_pkg::*;
#(
    parameter int unsigned SFILE_AW     = 8,
    parameter int unsigned NUM_LAYERS   = 3,
    parameter int unsigned MAX_PER_LINE = 64,
    parameter int unsigned SCREEN_W     = 360,
    localparam int unsigned LayerW      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [8:0]            i_line,
    input  logic                  i_s_en,
    input  logic                  i_v_ts,
    input  logic [7:0]            i_sgpage,
    input  logic [SFILE_AW-1:0]   i_sfile_addr,
    input  logic [15:0]           i_sfile_data,
    input  logic                  i_sfile_we,
    output logic                  o_tsr_go,
    input  logic                  i_tsr_rdy,
    output logic [5:0]            o_tsr_addr,
    output logic [8:0]            o_tsr_line,
    output logic [7:0]            o_tsr_page,
    output logic [8:0]            o_tsr_x,
    output logic [2:0]            o_tsr_xs,
    output logic                  o_tsr_xf,
    output logic [3:0]            o_tsr_pal,
    output logic [LayerW-1:0]     o_tsr_layer,
    output logic [NUM_LAYERS-1:0] o_layer_done,
    output logic                  o_spr_ovf
);

    localparam int unsigned NSPR = (1 << SFILE_AW) / SPR_WORDS;

    scan_state_e           r_state;
    logic [SFILE_AW-1:0]   r_sreg;
    logic [SFILE_AW-1:0]   r_idx;
    logic [LayerW-1:0]     r_layer;
    logic [7:0]            r_count;
    logic [NUM_LAYERS-1:0] r_layer_done;
    logic                  r_ovf;

    // Per-sprite values captured from R0 while R1/R2 are fetched
    logic [5:0]            r_sl;
    logic [2:0]            r_ysz;
    logic                  r_leap;
    logic                  r_yflp;

    logic [5:0]            r_tsr_addr;
    logic [8:0]            r_tsr_line;
    logic [7:0]            r_tsr_page;
    logic [8:0]            r_tsr_x;
    logic [2:0]            r_tsr_xs;
    logic                  r_tsr_xf;
    logic [3:0]            r_tsr_pal;

    logic [15:0]           w_rd_data;
    logic [8:0]            w_sl;
    logic [5:0]            w_ymax;
    logic                  w_vis;
    logic                  w_xvis;
    logic [5:0]            w_r_ymax;
    logic [5:0]            w_off;
    logic [8:0]            w_tline;
    logic                  w_finish;
    logic                  w_fin_leap;
    logic                  w_enable;

    video_ts_spr_scan_dpram #(
        .AW (SFILE_AW),
        .DW (16)
    ) u_sfile (
        .i_clk     (i_clk),
        .i_wr_addr (i_sfile_addr),
        .i_wr_data (i_sfile_data),
        .i_we      (i_sfile_we),
        .i_rd_addr (r_sreg),
        .o_rd_data (w_rd_data)
    );

    // Line-hit test on R0; the subtraction wraps on the 512-line ring
    assign w_sl   = i_line - w_rd_data[R0_Y_LSB +: 9];
    assign w_ymax = {w_rd_data[R0_YSZ_LSB +: 3], 3'b111};
    assign w_vis  = w_rd_data[R0_ACT] && (w_sl <= {3'b000, w_ymax});

    // X clip on R1
    assign w_xvis = x_visible(w_rd_data[R1_X_LSB +: 9], w_rd_data[R1_XSZ_LSB +: 3],
                              10'(SCREEN_W));

    // Row inside the sprite, mirrored when Y-flipped, added to the tile row base from R2
    assign w_r_ymax = {r_ysz, 3'b111};
    assign w_off    = r_yflp ? (w_r_ymax - r_sl) : r_sl;
    assign w_tline  = {w_rd_data[R2_TNUM_LSB + 6 +: 6], 3'b000} + {3'b000, w_off};

    // A sprite is finished when skipped (Y miss or X clip) or when its task is accepted
    assign w_finish = ((r_state == StRd0) && !w_vis) ||
                      ((r_state == StRd1) && !w_xvis) ||
                      ((r_state == StIssue) && i_tsr_rdy);
    assign w_fin_leap = (r_state == StRd0) ? w_rd_data[R0_LEAP] : r_leap;

    assign w_enable = i_s_en && i_v_ts;

    // Scanner FSM with limit, leap and end-of-file handling
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_sreg       <= '0;
            r_idx        <= '0;
            r_layer      <= '0;
            r_count      <= '0;
            r_layer_done <= '1;
            r_ovf        <= 1'b0;
            r_sl         <= '0;
            r_ysz        <= '0;
            r_leap       <= 1'b0;
            r_yflp       <= 1'b0;
            r_tsr_addr   <= '0;
            r_tsr_line   <= '0;
            r_tsr_page   <= '0;
            r_tsr_x      <= '0;
            r_tsr_xs     <= '0;
            r_tsr_xf     <= 1'b0;
            r_tsr_pal    <= '0;
        end else if (i_start) begin
            r_sreg       <= '0;
            r_idx        <= '0;
            r_layer      <= '0;
            r_count      <= '0;
            r_ovf        <= 1'b0;
            r_layer_done <= w_enable ? '0 : '1;
            r_state      <= w_enable ? StRd0Pre : StDone;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                end
                StRd0Pre: begin
                    // Pre-read the next sprite's R0 while this one's R0 is returned
                    r_sreg  <= r_sreg + SFILE_AW'(SPR_WORDS);
                    r_state <= StRd0;
                end
                StRd0: begin
                    if (w_vis) begin
                        r_sl    <= w_sl[5:0];
                        r_ysz   <= w_rd_data[R0_YSZ_LSB +: 3];
                        r_leap  <= w_rd_data[R0_LEAP];
                        r_yflp  <= w_rd_data[R0_YFLP];
                        r_sreg  <= r_sreg - SFILE_AW'(2);
                        r_state <= StRd1Pre;
                    end else begin
                        r_state <= StRd0Pre;
                    end
                end
                StRd1Pre: begin
                    r_sreg  <= r_sreg + SFILE_AW'(1);
                    r_state <= StRd1;
                end
                StRd1: begin
                    // Lands on the next sprite's R0 address for every exit path
                    r_sreg <= r_sreg + SFILE_AW'(1);
                    if (!w_xvis) begin
                        r_state <= StRd0Pre;
                    end else if (r_count == 8'(MAX_PER_LINE)) begin
                        r_ovf        <= 1'b1;
                        r_layer_done <= '1;
                        r_state      <= StDone;
                    end else begin
                        r_tsr_x  <= w_rd_data[R1_X_LSB +: 9];
                        r_tsr_xs <= w_rd_data[R1_XSZ_LSB +: 3];
                        r_tsr_xf <= w_rd_data[R1_XFLP];
                        r_state  <= StRd2;
                    end
                end
                StRd2: begin
                    r_tsr_addr <= w_rd_data[R2_TNUM_LSB +: 6];
                    r_tsr_line <= w_tline;
                    r_tsr_pal  <= w_rd_data[R2_PAL_LSB +: 4];
                    r_tsr_page <= i_sgpage;
                    r_state    <= StIssue;
                end
                StIssue: begin
                    if (i_tsr_rdy) begin
                        r_count <= r_count + 8'd1;
                        r_state <= StRd0Pre;
                    end
                end
                default: r_state <= StIdle;
            endcase

            // Leap and end-of-file override the next state chosen above
            if (w_finish) begin
                r_idx <= r_idx + SFILE_AW'(1);
                if (w_fin_leap) begin
                    r_layer_done[r_layer] <= 1'b1;
                    if (r_layer == LayerW'(NUM_LAYERS - 1)) begin
                        r_layer_done <= '1;
                        r_state      <= StDone;
                    end else begin
                        r_layer <= r_layer + LayerW'(1);
                    end
                end
                if (r_idx == SFILE_AW'(NSPR - 1)) begin
                    r_layer_done <= '1;
                    r_state      <= StDone;
                end
            end
        end
    end

    assign o_tsr_go     = (r_state == StIssue) && i_tsr_rdy && !i_start;
    assign o_tsr_addr   = r_tsr_addr;
    assign o_tsr_line   = r_tsr_line;
    assign o_tsr_page   = r_tsr_page;
    assign o_tsr_x      = r_tsr_x;
    assign o_tsr_xs     = r_tsr_xs;
    assign o_tsr_xf     = r_tsr_xf;
    assign o_tsr_pal    = r_tsr_pal;
    assign o_tsr_layer  = r_layer;
    assign o_layer_done = r_layer_done;
    assign o_spr_ovf    = r_ovf;

endmodule

// File: tb/tb_video_ts_spr_scan.sv
// Directed bench for the TS sprite scanner (default instance plus a 2-per-line limited one).
module tb_video_ts_spr_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [8:0] line;
    logic       s_en;
    logic       v_ts;
    logic [7:0] sgpage;
    logic [7:0] sf_addr;
    logic [15:0] sf_data;
    logic       sf_we;
    logic       rdy;

    logic       go,   go_l;
    logic [5:0] t_addr, t_addr_l;
    logic [8:0] t_line, t_line_l;
    logic [7:0] t_page, t_page_l;
    logic [8:0] t_x,    t_x_l;
    logic [2:0] t_xs,   t_xs_l;
    logic       t_xf,   t_xf_l;
    logic [3:0] t_pal,  t_pal_l;
    logic [1:0] t_lay,  t_lay_l;
    logic [2:0] ldone,  ldone_l;
    logic       ovf,    ovf_l;

    always #5 clk = ~clk;

    video_ts_spr_scan u_dut (
        .i_clk (clk), .i_rst (rst), .i_start (start), .i_line (line), .i_s_en (s_en),
        .i_v_ts (v_ts), .i_sgpage (sgpage), .i_sfile_addr (sf_addr), .i_sfile_data (sf_data),
        .i_sfile_we (sf_we), .o_tsr_go (go), .i_tsr_rdy (rdy), .o_tsr_addr (t_addr),
        .o_tsr_line (t_line), .o_tsr_page (t_page), .o_tsr_x (t_x), .o_tsr_xs (t_xs),
        .o_tsr_xf (t_xf), .o_tsr_pal (t_pal), .o_tsr_layer (t_lay), .o_layer_done (ldone),
        .o_spr_ovf (ovf)
    );

    video_ts_spr_scan #(.MAX_PER_LINE (2)) u_dut_lim (
        .i_clk (clk), .i_rst (rst), .i_start (start), .i_line (line), .i_s_en (s_en),
        .i_v_ts (v_ts), .i_sgpage (sgpage), .i_sfile_addr (sf_addr), .i_sfile_data (sf_data),
        .i_sfile_we (sf_we), .o_tsr_go (go_l), .i_tsr_rdy (rdy), .o_tsr_addr (t_addr_l),
        .o_tsr_line (t_line_l), .o_tsr_page (t_page_l), .o_tsr_x (t_x_l), .o_tsr_xs (t_xs_l),
        .o_tsr_xf (t_xf_l), .o_tsr_pal (t_pal_l), .o_tsr_layer (t_lay_l),
        .o_layer_done (ldone_l), .o_spr_ovf (ovf_l)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Task records captured on every go of the default instance
    int go_tot = 0;
    int go_tot_l = 0;
    int g_line [64];
    int g_addr [64];
    int g_x    [64];
    int g_xs   [64];
    int g_xf   [64];
    int g_pal  [64];
    int g_page [64];
    int g_lay  [64];
    int g_done [64];

    always @(negedge clk) begin
        if (go) begin
            if (go_tot < 64) begin
                g_line[go_tot] = int'(t_line);
                g_addr[go_tot] = int'(t_addr);
                g_x[go_tot]    = int'(t_x);
                g_xs[go_tot]   = int'(t_xs);
                g_xf[go_tot]   = int'(t_xf);
                g_pal[go_tot]  = int'(t_pal);
                g_page[go_tot] = int'(t_page);
                g_lay[go_tot]  = int'(t_lay);
                g_done[go_tot] = int'(ldone);
            end
            go_tot = go_tot + 1;
        end
        if (go_l) go_tot_l = go_tot_l + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks = n_checks + 1;
        if (got != exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input int addr, input logic [15:0] data);
        sf_addr = 8'(addr);
        sf_data = data;
        sf_we   = 1'b1;
        tick();
        sf_we   = 1'b0;
    endtask

    function automatic logic [15:0] mk_r0(input int y, input int ysz, input bit act,
                                          input bit leap, input bit yflp);
        logic [15:0] w;
        w = '0;
        w[8:0]  = 9'(y);
        w[11:9] = 3'(ysz);
        w[13]   = act;
        w[14]   = leap;
        w[15]   = yflp;
        return w;
    endfunction

    function automatic logic [15:0] mk_r1(input int x, input int xsz, input bit xflp);
        logic [15:0] w;
        w = '0;
        w[8:0]  = 9'(x);
        w[11:9] = 3'(xsz);
        w[15]   = xflp;
        return w;
    endfunction

    function automatic logic [15:0] mk_r2(input int tnum, input int pal);
        logic [15:0] w;
        w = '0;
        w[11:0]  = 12'(tnum);
        w[15:12] = 4'(pal);
        return w;
    endfunction

    task automatic wr_spr(input int idx, input logic [15:0] r0, input logic [15:0] r1,
                          input logic [15:0] r2);
        wr_word(3 * idx, r0);
        wr_word(3 * idx + 1, r1);
        wr_word(3 * idx + 2, r2);
    endtask

    task automatic clear_all();
        for (int i = 0; i < 85; i++) wr_word(3 * i, 16'h0000);
    endtask

    // Pulse start and wait (bounded) for both instances to finish the line
    task automatic run_line(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (ldone == 3'b111 && ldone_l == 3'b111) break;
            tick();
        end
        check_eq({tag, "_end"}, int'(ldone), 3'b111);
        check_eq({tag, "_end_lim"}, int'(ldone_l), 3'b111);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int base_l;
        rst = 1'b1; start = 1'b0; line = 9'd12; s_en = 1'b1; v_ts = 1'b1;
        sgpage = 8'h3A; sf_addr = '0; sf_data = '0; sf_we = 1'b0; rdy = 1'b1;
        repeat (3) tick();

        // Reset state
        check_eq("rst_go", int'(go), 0);
        check_eq("rst_done", int'(ldone), 3'b111);
        check_eq("rst_ovf", int'(ovf), 0);
        check_eq("rst_line", int'(t_line), 0);
        rst = 1'b0;
        tick();

        // Single visible sprite
        clear_all();
        wr_spr(0, mk_r0(10, 1, 1, 0, 0), mk_r1(100, 2, 1), mk_r2(12'h0C5, 9));
        base = go_tot;
        run_line("basic");
        check_eq("basic_ngo", go_tot - base, 1);
        check_eq("basic_line", g_line[base], 26);
        check_eq("basic_addr", g_addr[base], 5);
        check_eq("basic_x", g_x[base], 100);
        check_eq("basic_xs", g_xs[base], 2);
        check_eq("basic_xf", g_xf[base], 1);
        check_eq("basic_pal", g_pal[base], 9);
        check_eq("basic_page", g_page[base], 8'h3A);
        check_eq("basic_layer", g_lay[base], 0);

        // Y-flipped
        wr_word(0, mk_r0(10, 1, 1, 0, 1));
        base = go_tot;
        run_line("yflp");
        check_eq("yflp_ngo", go_tot - base, 1);
        check_eq("yflp_line", g_line[base], 37);

        // Line miss: y=20 ysz=0 does not cover line 12
        wr_word(0, mk_r0(20, 0, 1, 0, 0));
        base = go_tot;
        run_line("miss");
        check_eq("miss_ngo", go_tot - base, 0);

        // Leap closes layer 0 after the first task
        clear_all();
        wr_spr(0, mk_r0(10, 1, 1, 1, 0), mk_r1(50, 0, 0), mk_r2(12'h001, 1));
        wr_spr(1, mk_r0(10, 1, 1, 0, 0), mk_r1(60, 0, 0), mk_r2(12'h002, 2));
        base = go_tot;
        run_line("leap");
        check_eq("leap_ngo", go_tot - base, 2);
        check_eq("leap_lay0", g_lay[base], 0);
        check_eq("leap_done0", g_done[base], 3'b000);
        check_eq("leap_lay1", g_lay[base + 1], 1);
        check_eq("leap_done1", g_done[base + 1], 3'b001);

        // X clipping
        clear_all();
        wr_spr(0, mk_r0(10, 1, 1, 0, 0), mk_r1(400, 0, 0), mk_r2(0, 0));
        wr_spr(1, mk_r0(10, 1, 1, 0, 0), mk_r1(508, 0, 0), mk_r2(0, 0));
        wr_spr(2, mk_r0(10, 1, 1, 0, 0), mk_r1(359, 0, 0), mk_r2(0, 0));
        wr_spr(3, mk_r0(10, 1, 1, 0, 0), mk_r1(360, 7, 0), mk_r2(0, 0));
        base = go_tot;
        run_line("xclip");
        check_eq("xclip_ngo", go_tot - base, 2);
        check_eq("xclip_x0", g_x[base], 508);
        check_eq("xclip_x1", g_x[base + 1], 359);

        // Per-line limit (limited instance allows 2)
        clear_all();
        for (int i = 0; i < 4; i++)
            wr_spr(i, mk_r0(10, 1, 1, 0, 0), mk_r1(10 * i, 0, 0), mk_r2(i, 0));
        base = go_tot;
        base_l = go_tot_l;
        run_line("limit");
        check_eq("limit_ngo_lim", go_tot_l - base_l, 2);
        check_eq("limit_ovf_lim", int'(ovf_l), 1);
        check_eq("limit_ngo", go_tot - base, 4);
        check_eq("limit_ovf", int'(ovf), 0);

        // Renderer stall, then start while in ISSUE with rdy
        clear_all();
        wr_spr(0, mk_r0(10, 1, 1, 0, 0), mk_r1(100, 2, 1), mk_r2(12'h0C5, 9));
        rdy = 1'b0;
        base = go_tot;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check_eq("stall_ngo", go_tot - base, 0);
        check_eq("stall_line", int'(t_line), 26);
        check_eq("stall_x", int'(t_x), 100);
        check_eq("stall_done", int'(ldone), 3'b000);
        start = 1'b1;
        rdy = 1'b1;
        #2;
        check_eq("start_go", int'(go), 0);
        tick();
        start = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (ldone == 3'b111) break;
            tick();
        end
        check_eq("restart_end", int'(ldone), 3'b111);
        check_eq("restart_ngo", go_tot - base, 1);
        check_eq("restart_line", g_line[base], 26);

        // Asynchronous reset mid-scan
        rdy = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rdy = 1'b1;
        rst = 1'b1;
        #1;
        check_eq("arst_go", int'(go), 0);
        check_eq("arst_x", int'(t_x), 0);
        check_eq("arst_line", int'(t_line), 0);
        check_eq("arst_done", int'(ldone), 3'b111);
        tick();
        rst = 1'b0;
        tick();

        // Sprites disabled at start
        s_en = 1'b0;
        base = go_tot;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_eq("dis_done", int'(ldone), 3'b111);
        repeat (20) tick();
        check_eq("dis_ngo", go_tot - base, 0);
        s_en = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
